// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster position counter with registered draw coordinates, sync and frame markers.
// Outputs lag the internal (hc,vc) counter by one edge; hs_pin/vs_pin add PIPE_DELAY further edges.
module vga_timing_gen #(
    parameter int unsigned H_VISIBLE  = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_VISIBLE  = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic       vga_clk,
    input  logic       reset,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       hs_pin,
    output logic       vs_pin,
    output logic       line_start,
    output logic       frame_start,
    output logic [7:0] frame_count
);
    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
    end
    if (PIPE_DELAY > 4) begin : g_bad_delay
        $error("vga_timing_gen: PIPE_DELAY must be in 0..4");
    end

    // Inclusive bounds keep every threshold inside 10 bits even when a total is exactly 1024.
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_LAST = 10'(H_VISIBLE - 1);
    localparam logic [9:0] V_VIS_LAST = 10'(V_VISIBLE - 1);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    logic [9:0] hc, vc;
    logic       hc_end, at_origin, hs_next, vs_next, blank_next;

    always_comb begin
        hc_end     = hc == H_LAST;
        at_origin  = hc == '0 && vc == '0;
        hs_next    = (hc >= HS_FIRST && hc <= HS_LAST) ? SYNC_POL : ~SYNC_POL;
        vs_next    = (vc >= VS_FIRST && vc <= VS_LAST) ? SYNC_POL : ~SYNC_POL;
        blank_next = hc <= H_VIS_LAST && vc <= V_VIS_LAST;
    end

    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hc <= '0;
            vc <= '0;
        end else begin
            hc <= hc_end ? '0 : hc + 10'd1;
            vc <= hc_end ? (vc == V_LAST ? '0 : vc + 10'd1) : vc;
        end
    end

    // Every presented field is loaded from the same (hc,vc), so one output cycle describes one pixel.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            DrawX       <= '0;
            DrawY       <= '0;
            blank       <= 1'b0;
            hs          <= ~SYNC_POL;
            vs          <= ~SYNC_POL;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            DrawX       <= hc;
            DrawY       <= vc;
            blank       <= blank_next;
            hs          <= hs_next;
            vs          <= vs_next;
            line_start  <= hc == '0;
            frame_start <= at_origin;
            frame_count <= frame_count + {7'd0, at_origin};
        end
    end

    if (PIPE_DELAY == 0) begin : g_no_pipe
        always_comb begin
            hs_pin = hs;
            vs_pin = vs;
        end
    end else begin : g_pipe
        logic [PIPE_DELAY-1:0] hs_sr, vs_sr;
        always_ff @(posedge vga_clk or posedge reset) begin
            if (reset) begin
                hs_sr <= {PIPE_DELAY{~SYNC_POL}};
                vs_sr <= {PIPE_DELAY{~SYNC_POL}};
            end else begin
                hs_sr <= PIPE_DELAY'({hs_sr, hs});
                vs_sr <= PIPE_DELAY'({vs_sr, vs});
            end
        end
        always_comb begin
            hs_pin = hs_sr[PIPE_DELAY-1];
            vs_pin = vs_sr[PIPE_DELAY-1];
        end
    end
endmodule
